// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, a one-entry skid buffer,
// flush (bubble insert) and a saturating upstream stall counter.
module pipe_stage_skid #(
  parameter int                INST_W   = 32,
  parameter int                DATA_W   = 64,
  parameter int                CTRL_W   = 3,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [INST_W-1:0] main_inst, skid_inst;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  logic accept, emit, stall_hit;
  logic load_main_in, load_main_skid, load_skid;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and in_ready depends only on state.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  // A flushed input is dropped rather than held back, so it is not a stall.
  assign stall_hit = in_valid & ~in_ready & ~flush;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && emit) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (emit) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_inst <= NOP_INST;
      main_data <= '0;
      main_ctrl <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_next;
      if (load_main_in) begin
        main_inst <= in_inst;
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        main_inst <= skid_inst;
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (stall_hit && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  // Skid contents are only meaningful while in FULL, so they need no reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_inst <= in_inst;
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
    end
  end

  assign out_inst  = out_valid ? main_inst : NOP_INST;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = state;

endmodule
